// File: rtl/gemm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gemm_pkg
// Purpose  : Shared state encoding, default geometry and sizing helper for the
//            systolic GEMM engine.
// Revision : 1.0 - initial release
// ============================================================================
package gemm_pkg;

   localparam int DEFAULT_ROWS   = 4;
   localparam int DEFAULT_COLS   = 4;
   localparam int DEFAULT_DATA_W = 16;
   localparam int DEFAULT_ACC_W  = 32;

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      FLUSH = 2'd1,
      DRAIN = 2'd2
   } gemm_state_t;

   // Index width that never collapses to zero bits (a 1-row array still gets a 1-bit index)
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage
`default_nettype wire

// File: rtl/systolic_pe.sv
`default_nettype none
// ============================================================================
// Module   : systolic_pe
// Purpose  : Output-stationary processing element. Forwards A right and B
//            down through tagged pass registers and accumulates a*b whenever
//            both incoming tags are valid.
// Revision : 1.0 - initial release
// ============================================================================
module systolic_pe #(
   parameter int DATA_W = 16,
   parameter int ACC_W  = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic [DATA_W-1:0] a_in,
   input  logic              a_in_v,
   input  logic [DATA_W-1:0] b_in,
   input  logic              b_in_v,
   output logic [DATA_W-1:0] a_out,
   output logic              a_out_v,
   output logic [DATA_W-1:0] b_out,
   output logic              b_out_v,
   output logic [ACC_W-1:0]  acc
);

   logic signed [2*DATA_W-1:0] a_ext;
   logic signed [2*DATA_W-1:0] b_ext;
   logic signed [2*DATA_W-1:0] prod;
   logic signed [ACC_W-1:0]    prod_ext;

   // Full-precision signed product, sign-extended to the accumulator width
   assign a_ext    = (2*DATA_W)'($signed(a_in));
   assign b_ext    = (2*DATA_W)'($signed(b_in));
   assign prod     = a_ext * b_ext;
   assign prod_ext = ACC_W'(prod);

   // Pass registers, tags and wrapping accumulator; clr wipes the PE after a drain
   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         a_out   <= '0;
         a_out_v <= 1'b0;
         b_out   <= '0;
         b_out_v <= 1'b0;
         acc     <= '0;
      end else begin
         a_out   <= a_in;
         a_out_v <= a_in_v;
         b_out   <= b_in;
         b_out_v <= b_in_v;
         if (a_in_v && b_in_v) begin
            acc <= acc + prod_ext;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/systolic_gemm_array.sv
`default_nettype none
// ============================================================================
// Module   : systolic_gemm_array
// Purpose  : Parametrised output-stationary systolic GEMM engine with input
//            skewing, LOAD/FLUSH/DRAIN sequencing and a row-wise result port.
// Revision : 1.0 - initial release
// ============================================================================
module systolic_gemm_array
   import gemm_pkg::*;
#(
   parameter int ROWS   = DEFAULT_ROWS,
   parameter int COLS   = DEFAULT_COLS,
   parameter int DATA_W = DEFAULT_DATA_W,
   parameter int ACC_W  = DEFAULT_ACC_W
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic                         in_last,
   input  logic [ROWS*DATA_W-1:0]       in_a,
   input  logic [COLS*DATA_W-1:0]       in_b,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [COLS*ACC_W-1:0]        out_row,
   output logic [clog2_min1(ROWS)-1:0]  out_idx,
   output logic                         out_last,
   output logic                         busy
);

   localparam int IDX_W     = clog2_min1(ROWS);
   localparam int FLUSH_LEN = ROWS + COLS - 1;
   localparam int CNT_W     = clog2_min1(ROWS + COLS);
   localparam logic [CNT_W-1:0] FLUSH_INIT = CNT_W'(FLUSH_LEN - 1);
   localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(ROWS - 1);

   if (ACC_W < 2*DATA_W) begin : g_acc_w_check
      $error("systolic_gemm_array: ACC_W must be at least 2*DATA_W");
   end
   if (ROWS < 1 || COLS < 1) begin : g_geom_check
      $error("systolic_gemm_array: ROWS and COLS must be at least 1");
   end

   gemm_state_t      state;
   gemm_state_t      next_state;
   logic [IDX_W-1:0] idx_next;
   logic [CNT_W-1:0] flush_cnt;
   logic             accept;
   logic             out_fire;
   logic             drain_done;

   logic [DATA_W-1:0] cap_a [ROWS];
   logic [DATA_W-1:0] cap_b [COLS];
   logic              cap_v;

   logic [DATA_W-1:0] a_edge   [ROWS];
   logic              a_edge_v [ROWS];
   logic [DATA_W-1:0] b_edge   [COLS];
   logic              b_edge_v [COLS];

   logic [DATA_W-1:0] a_h  [ROWS][COLS];
   logic              a_hv [ROWS][COLS];
   logic [DATA_W-1:0] b_d  [ROWS][COLS];
   logic              b_dv [ROWS][COLS];
   logic [ACC_W-1:0]  acc  [ROWS][COLS];

   // in_ready is only ever high in LOAD, so it alone qualifies a beat
   assign accept     = in_valid & in_ready;
   assign out_fire   = out_valid & out_ready;
   assign drain_done = out_fire & out_last;

   // Capture the accepted K-slice; the capture tag marks a real beat versus a bubble
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cap_v <= 1'b0;
         for (int i = 0; i < ROWS; i++) cap_a[i] <= '0;
         for (int j = 0; j < COLS; j++) cap_b[j] <= '0;
      end else begin
         cap_v <= accept;
         if (accept) begin
            for (int i = 0; i < ROWS; i++) cap_a[i] <= in_a[i*DATA_W +: DATA_W];
            for (int j = 0; j < COLS; j++) cap_b[j] <= in_b[j*DATA_W +: DATA_W];
         end
      end
   end

   // A-side skew: lane i is delayed by i extra registers so it meets B on the diagonal
   for (genvar i = 0; i < ROWS; i++) begin : g_a_skew
      if (i == 0) begin : g_direct
         assign a_edge[i]   = cap_a[i];
         assign a_edge_v[i] = cap_v;
      end else begin : g_chain
         logic [DATA_W-1:0] sd [i];
         logic [i-1:0]      sv;
         // Shift the lane data and its tag one stage per clock
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               for (int s = 0; s < i; s++) sd[s] <= '0;
               sv <= '0;
            end else begin
               sd[0] <= cap_a[i];
               sv[0] <= cap_v;
               for (int s = 1; s < i; s++) begin
                  sd[s] <= sd[s-1];
                  sv[s] <= sv[s-1];
               end
            end
         end
         assign a_edge[i]   = sd[i-1];
         assign a_edge_v[i] = sv[i-1];
      end
   end

   // B-side skew: lane j is delayed by j extra registers
   for (genvar j = 0; j < COLS; j++) begin : g_b_skew
      if (j == 0) begin : g_direct
         assign b_edge[j]   = cap_b[j];
         assign b_edge_v[j] = cap_v;
      end else begin : g_chain
         logic [DATA_W-1:0] sd [j];
         logic [j-1:0]      sv;
         // Shift the lane data and its tag one stage per clock
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               for (int s = 0; s < j; s++) sd[s] <= '0;
               sv <= '0;
            end else begin
               sd[0] <= cap_b[j];
               sv[0] <= cap_v;
               for (int s = 1; s < j; s++) begin
                  sd[s] <= sd[s-1];
                  sv[s] <= sv[s-1];
               end
            end
         end
         assign b_edge[j]   = sd[j-1];
         assign b_edge_v[j] = sv[j-1];
      end
   end

   // PE grid: A flows right along a row, B flows down a column
   for (genvar i = 0; i < ROWS; i++) begin : g_row
      for (genvar j = 0; j < COLS; j++) begin : g_col
         logic [DATA_W-1:0] a_src;
         logic              a_src_v;
         logic [DATA_W-1:0] b_src;
         logic              b_src_v;

         if (j == 0) begin : g_a_from_skew
            assign a_src   = a_edge[i];
            assign a_src_v = a_edge_v[i];
         end else begin : g_a_from_left
            assign a_src   = a_h[i][j-1];
            assign a_src_v = a_hv[i][j-1];
         end

         if (i == 0) begin : g_b_from_skew
            assign b_src   = b_edge[j];
            assign b_src_v = b_edge_v[j];
         end else begin : g_b_from_above
            assign b_src   = b_d[i-1][j];
            assign b_src_v = b_dv[i-1][j];
         end

         systolic_pe #(
            .DATA_W (DATA_W),
            .ACC_W  (ACC_W)
         ) u_pe (
            .clk     (clk),
            .rst_n   (rst_n),
            .clr     (drain_done),
            .a_in    (a_src),
            .a_in_v  (a_src_v),
            .b_in    (b_src),
            .b_in_v  (b_src_v),
            .a_out   (a_h[i][j]),
            .a_out_v (a_hv[i][j]),
            .b_out   (b_d[i][j]),
            .b_out_v (b_dv[i][j]),
            .acc     (acc[i][j])
         );
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) state <= LOAD;
      else        state <= next_state;
   end

   // Next-state and next drain index
   always_comb begin
      next_state = state;
      idx_next   = out_idx;
      unique case (state)
         LOAD: begin
            if (accept && in_last) next_state = FLUSH;
         end
         FLUSH: begin
            if (flush_cnt == '0) next_state = DRAIN;
         end
         DRAIN: begin
            if (out_fire) begin
               if (out_last) begin
                  next_state = LOAD;
                  idx_next   = '0;
               end else begin
                  idx_next = out_idx + 1'b1;
               end
            end
         end
         default: next_state = LOAD;
      endcase
   end

   // Registered handshake/status outputs and the flush down-counter
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         out_idx   <= '0;
         out_last  <= 1'b0;
         busy      <= 1'b0;
         flush_cnt <= FLUSH_INIT;
      end else begin
         in_ready  <= (next_state == LOAD);
         out_valid <= (next_state == DRAIN);
         out_idx   <= idx_next;
         out_last  <= (next_state == DRAIN) && (idx_next == LAST_IDX);
         busy      <= (next_state != LOAD) || ((state == LOAD) && (busy || accept));
         flush_cnt <= (state == FLUSH) ? flush_cnt - 1'b1 : FLUSH_INIT;
      end
   end

   // Drain mux: selects accumulator row out_idx (accumulators are frozen in DRAIN)
   always_comb begin
      out_row = '0;
      for (int j = 0; j < COLS; j++) begin
         out_row[j*ACC_W +: ACC_W] = acc[out_idx][j];
      end
   end

endmodule
`default_nettype wire
